seq_detect_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 11011 overlapping Mealy sequence-detect engine among NCH serial bit channels.
- Each channel keeps its own saved 3-bit detector state. Per cycle, the scheduler grants one requesting channel, advances that channel's state with its bit, and reports a match tagged with the channel number.
- Sits between the serial front-end channels and the event/status logic.

---
 rtl/seq_detect_rr_sched_if.sv | 27 ++
 rtl/seq_detect_rr_sched.sv | 109 ++++++++++
 tb/tb_seq_detect_rr_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_rr_sched_if.sv
// Bus bundle between the serial front-end channels and the shared 11011 detector.
// The front end drives the master side; the scheduler implements the slave side.
interface seq_detect_rr_sched_if #(
   parameter int NCH  = 4,
   parameter int CHW  = 2,
   parameter int CNTW = 8
);
   logic                i_enable;
   logic [NCH-1:0]      i_req;
   logic [NCH-1:0]      i_din;
   logic [NCH-1:0]      i_chan_clr;
   logic [NCH-1:0]      o_gnt;
   logic                o_match;
   logic [CHW-1:0]      o_match_ch;
   logic [CNTW-1:0]     o_match_total;
   logic [3*NCH-1:0]    o_ch_state;

   modport master (
      output i_enable, i_req, i_din, i_chan_clr,
      input  o_gnt, o_match, o_match_ch, o_match_total, o_ch_state
   );

   modport slave (
      input  i_enable, i_req, i_din, i_chan_clr,
      output o_gnt, o_match, o_match_ch, o_match_total, o_ch_state
   );
endinterface

// File: rtl/seq_detect_rr_sched.sv
// Round-robin scheduler sharing one overlapping 11011 Mealy detector among NCH
// serial channels; each channel keeps its own saved 3-bit detector state.
module seq_detect_rr_sched #(
   parameter int NCH  = 4,
   parameter int CHW  = 2,
   parameter int CNTW = 8
) (
   input  logic                 i_clk,
   input  logic                 i_clear,
   seq_detect_rr_sched_if.slave bus
);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;

   logic [2:0]      r_state [NCH];
   logic [CHW-1:0]  r_ptr;
   logic            r_match;
   logic [CHW-1:0]  r_match_ch;
   logic [CNTW-1:0] r_total;

   logic [NCH-1:0]  w_elig;
   logic            w_grant_any;
   logic [CHW-1:0]  w_grant_idx;
   logic [NCH-1:0]  w_gnt;
   logic [2:0]      w_cur;
   logic            w_bit;
   logic [2:0]      w_next;
   logic            w_hit;
   logic [3*NCH-1:0] w_ch_state;

   // A channel being cleared this cycle is not allowed to consume its bit.
   assign w_elig = i_clear ? '0 : ({NCH{bus.i_enable}} & bus.i_req & ~bus.i_chan_clr);

   // Search ptr+1, ptr+2, ... with wrap; the first eligible channel wins.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      for (int k = 1; k <= NCH; k++) begin
         if (!w_grant_any && w_elig[(int'(r_ptr) + k) % NCH]) begin
            w_grant_any = 1'b1;
            w_grant_idx = CHW'((int'(r_ptr) + k) % NCH);
         end
      end
      w_gnt = w_grant_any ? (NCH'(1) << w_grant_idx) : '0;
   end

   assign w_cur = r_state[w_grant_idx];
   assign w_bit = bus.i_din[w_grant_idx];

   always_comb begin
      w_next = S0;
      w_hit  = 1'b0;
      case (w_cur)
         S0: w_next = w_bit ? S1 : S0;
         S1: w_next = w_bit ? S2 : S0;
         S2: w_next = w_bit ? S2 : S3;
         S3: w_next = w_bit ? S4 : S0;
         S4: begin
            // Overlap: the trailing "11" of a match is the start of the next one.
            w_next = w_bit ? S2 : S0;
            w_hit  = w_bit;
         end
         default: w_next = S0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         // NOTE: the per-channel state array is small register storage, so it is reset explicitly.
         for (int i = 0; i < NCH; i++) r_state[i] <= S0;
         r_ptr      <= CHW'(NCH - 1);
         r_match    <= 1'b0;
         r_match_ch <= '0;
         r_total    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         for (int i = 0; i < NCH; i++) begin
            if (bus.i_chan_clr[i])
               r_state[i] <= S0;
            else if (w_grant_any && (w_grant_idx == CHW'(i)))
               r_state[i] <= w_next;
         end
         r_match <= w_grant_any & w_hit;
         if (w_grant_any) begin
            r_ptr      <= w_grant_idx;
            r_match_ch <= w_grant_idx;
         end
         if (w_grant_any && w_hit && (r_total != {CNTW{1'b1}}))
            r_total <= r_total + 1'b1;
      end
   end

   always_comb begin
      w_ch_state = '0;
      for (int i = 0; i < NCH; i++) w_ch_state[3*i +: 3] = r_state[i];
   end

   assign bus.o_gnt         = w_gnt;
   assign bus.o_match       = r_match;
   assign bus.o_match_ch    = r_match_ch;
   assign bus.o_match_total = r_total;
   assign bus.o_ch_state    = w_ch_state;

endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// Self-checking bench: directed scenarios plus random traffic compared with a
// history-based model of the 11011 search and round-robin arbitration.
module tb_seq_detect_rr_sched;

   localparam int NCH  = 4;
   localparam int CHW  = 2;
   localparam int CNTW = 2;
   localparam int MAXT = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic clear;

   always #5 clk = ~clk;

   seq_detect_rr_sched_if #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) bus ();

   seq_detect_rr_sched #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
      .i_clk   (clk),
      .i_clear (clear),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: last five consumed bits per channel (newest in bit 0) and how many
   // bits have been consumed since the last clear, capped at five.
   int m_hist [NCH];
   int m_len  [NCH];
   int m_ptr;
   int m_match;
   int m_ch;
   int m_total;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Detector state = length of the longest consumed suffix that is a prefix of 1101.
   function automatic logic [2:0] exp_state(input int ch);
      for (int l = 4; l >= 1; l--) begin
         if (m_len[ch] >= l && ((m_hist[ch] & ((1 << l) - 1)) == (27 >> (5 - l))))
            return 3'(l);
      end
      return 3'd0;
   endfunction

   function automatic int pick(input logic clr, input logic en,
                               input logic [NCH-1:0] rq, input logic [NCH-1:0] cc);
      if (clr || !en) return -1;
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (rq[c] && !cc[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_hist[i] = 0;
         m_len[i]  = 0;
      end
      m_ptr = NCH - 1; m_match = 0; m_ch = 0; m_total = 0;
   endtask

   task automatic model_update(input logic clr, input logic [NCH-1:0] dn,
                               input logic [NCH-1:0] cc, input int g);
      if (clr) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         if (cc[i]) begin
            m_hist[i] = 0;
            m_len[i]  = 0;
         end
      end
      m_match = 0;
      if (g >= 0) begin
         m_hist[g] = ((m_hist[g] << 1) | int'(dn[g])) & 31;
         m_len[g]  = (m_len[g] < 5) ? m_len[g] + 1 : 5;
         m_match   = (m_len[g] == 5 && m_hist[g] == 27) ? 1 : 0;
         m_ch      = g;
         m_ptr     = g;
         if (m_match == 1 && m_total < MAXT) m_total++;
      end
   endtask

   task automatic step(input logic clr, input logic en, input logic [NCH-1:0] rq,
                       input logic [NCH-1:0] dn, input logic [NCH-1:0] cc);
      int g;
      logic [NCH-1:0] eg;
      logic [3*NCH-1:0] es;
      @(negedge clk);
      clear          = clr;
      bus.i_enable   = en;
      bus.i_req      = rq;
      bus.i_din      = dn;
      bus.i_chan_clr = cc;
      #1;
      g  = pick(clr, en, rq, cc);
      eg = (g < 0) ? '0 : (NCH'(1) << g);
      check("gnt", 32'(bus.o_gnt), 32'(eg));
      @(posedge clk);
      #1;
      model_update(clr, dn, cc, g);
      for (int i = 0; i < NCH; i++) es[3*i +: 3] = exp_state(i);
      check("match", 32'(bus.o_match), 32'(m_match));
      check("match_ch", 32'(bus.o_match_ch), 32'(m_ch));
      check("match_total", 32'(bus.o_match_total), 32'(m_total));
      check("ch_state", 32'(bus.o_ch_state), 32'(es));
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, '1, '1, '0);
   endtask

   // Feed n bits of a pattern (MSB first) on one channel, others idle.
   task automatic feed(input int ch, input logic [31:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--)
         step(1'b0, 1'b1, NCH'(1) << ch, NCH'(bits[k]) << ch, '0);
   endtask

   initial begin
      model_reset();
      clear = 1'b1; bus.i_enable = 1'b0; bus.i_req = '0; bus.i_din = '0; bus.i_chan_clr = '0;

      // Reset state and single-channel detection.
      do_reset();
      check("rst_state", 32'(bus.o_ch_state), 32'd0);
      check("rst_total", 32'(bus.o_match_total), 32'd0);
      feed(0, 32'b11011, 5);
      check("single_match", 32'(bus.o_match), 32'd1);
      check("single_ch", 32'(bus.o_match_ch), 32'd0);
      check("single_state", 32'(bus.o_ch_state[2:0]), 32'd2);

      // Overlapping matches.
      do_reset();
      feed(0, 32'b11011011, 8);
      check("overlap_total", 32'(bus.o_match_total), 32'd2);

      // Fairness with every channel requesting.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 4'b1111, 4'($urandom), '0);
         check("fair_ch", 32'(bus.o_match_ch), 32'(k % NCH));
      end

      // Interleaving ch1 and ch3, each fed 11011.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         logic [4:0] pat;
         logic b;
         pat = 5'b11011;
         b   = pat[4 - k / 2];
         step(1'b0, 1'b1, 4'b1010, {b, 1'b0, b, 1'b0}, '0);
         if (k == 8) check("il_match1", 32'({bus.o_match, bus.o_match_ch}), 32'({1'b1, 2'd1}));
         if (k == 9) check("il_match3", 32'({bus.o_match, bus.o_match_ch}), 32'({1'b1, 2'd3}));
      end
      check("il_idle_states", 32'(bus.o_ch_state & 12'h1C7), 32'd0);

      // chan_clr on ch2 in S4 blocks its grant and its match.
      do_reset();
      feed(2, 32'b1101, 4);
      check("cc_pre_state", 32'(bus.o_ch_state[8:6]), 32'd4);
      step(1'b0, 1'b1, 4'b0101, 4'b0101, 4'b0100);
      check("cc_no_match", 32'(bus.o_match), 32'd0);
      check("cc_state", 32'(bus.o_ch_state[8:6]), 32'd0);
      check("cc_other", 32'(bus.o_match_ch), 32'd0);

      // Saturation of the total counter.
      do_reset();
      feed(0, 32'b11011011011011011, 17);
      check("sat_total", 32'(bus.o_match_total), 32'(MAXT));

      // Clear mid-pattern: no match across it, first grant to ch0.
      feed(0, 32'b1101, 4);
      do_reset();
      check("mid_rst_state", 32'(bus.o_ch_state), 32'd0);
      step(1'b0, 1'b1, 4'b0001, 4'b0001, '0);
      check("mid_rst_nomatch", 32'(bus.o_match), 32'd0);

      // enable=0 holds everything.
      step(1'b0, 1'b0, 4'b1111, 4'b1111, '0);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         logic clr, en;
         logic [NCH-1:0] rq, dn, cc;
         clr = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 7) != 0);
         rq  = NCH'($urandom);
         dn  = NCH'($urandom | $urandom);
         cc  = NCH'($urandom & $urandom & $urandom & $urandom);
         step(clr, en, rq, dn, cc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
